fetch_queue: RTL and testbench

FETCH_QUEUE -- requirements
Module: fetch_queue

---
 rtl/fetch_pkg.sv | 11 +
 rtl/fq_fifo.sv | 61 ++++++
 rtl/fetch_queue.sv | 74 +++++++
 tb/tb_fetch_queue.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared constants and the queue entry layout for the instruction fetch queue.
package fetch_pkg;
  localparam int unsigned FQ_DEPTH    = 4;
  localparam logic [31:0] FQ_RESET_PC = 32'h0000_0000;
  localparam int unsigned FQ_ENTRY_W  = 64;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fq_entry_t;
endpackage

// File: rtl/fq_fifo.sv
// Synchronous FIFO holding fetched {PC, instruction} entries; head is read
// asynchronously so a freshly written entry is visible the following cycle.
module fq_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = FQ_DEPTH
) (
  input  logic                   clk,
  input  logic                   srst,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic                   flush_i,
  input  fq_entry_t              wdata_i,
  output fq_entry_t              rdata_o,
  output logic [$clog2(DEPTH):0] count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  fq_entry_t mem_q [DEPTH];

  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          pop_ok, push_ok;

  // Guards keep the count in range even if the caller misbehaves.
  always_comb begin
    pop_ok  = pop_i && (cnt_q != '0);
    push_ok = push_i && ((cnt_q != FULL_CNT) || pop_ok);
    wr_d    = wr_q + AW'(push_ok);
    rd_d    = rd_q + AW'(pop_ok);
    cnt_d   = cnt_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    if (flush_i) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage is deliberately not reset; only pointers and count are.
  always_ff @(posedge clk) begin
    if (push_ok && !flush_i && !srst) begin
      mem_q[wr_q] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[rd_q];
  assign count_o = cnt_q;
endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch queue: owns the fetch PC, decodes push/pop and applies
// branch redirects, with entries buffered in fq_fifo.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int          DEPTH    = FQ_DEPTH,
  parameter logic [31:0] RESET_PC = FQ_RESET_PC
) (
  input  logic                   Clk,
  input  logic                   Clr,
  input  logic                   Redirect,
  input  logic [31:0]            Redirect_PC,
  output logic [31:0]            Imem_Addr,
  input  logic [31:0]            Imem_Inst,
  input  logic                   ID_Ready,
  output logic                   Out_Valid,
  output logic [31:0]            Out_PC,
  output logic [31:0]            Out_PC4,
  output logic [31:0]            Out_Inst,
  output logic [$clog2(DEPTH):0] Count
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [31:0] pc_q, pc_d;
  logic        push, pop;
  fq_entry_t   wr_entry, head;
  logic [CW-1:0] cnt;
  logic          unused_redirect_lsbs;

  assign unused_redirect_lsbs = ^Redirect_PC[1:0];

  // Clr masks the head so nothing partial escapes during reset.
  assign Out_Valid = (cnt != '0) && !Redirect && !Clr;
  assign pop       = Out_Valid && ID_Ready;
  assign push      = !Redirect && ((cnt != FULL_CNT) || pop);
  assign Imem_Addr = Clr ? RESET_PC : pc_q;

  always_comb begin
    pc_d = pc_q;
    if (Redirect) begin
      pc_d = {Redirect_PC[31:2], 2'b00};
    end else if (push) begin
      pc_d = pc_q + 32'd4;
    end
  end

  always_ff @(posedge Clk) begin
    if (Clr) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign wr_entry.pc   = pc_q;
  assign wr_entry.inst = Imem_Inst;

  fq_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (Clk),
    .srst    (Clr),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (Redirect),
    .wdata_i (wr_entry),
    .rdata_o (head),
    .count_o (cnt)
  );

  assign Count    = cnt;
  assign Out_PC   = Out_Valid ? head.pc : 32'd0;
  assign Out_PC4  = Out_Valid ? head.pc + 32'd4 : 32'd0;
  assign Out_Inst = Out_Valid ? head.inst : 32'd0;
endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed vector table, a wrap-around instance and a
// randomized run against a queue-based reference model.
module tb_fetch_queue;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        clr, redir, ready;
  logic [31:0] rpc, addr, inst, opc, opc4, oinst;
  logic        valid;
  logic [2:0]  count;

  logic        clr2;
  logic [31:0] addr2, inst2, opc2, opc42, oinst2;
  logic        valid2;
  logic [2:0]  count2;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return (a * 32'd2654435761) ^ 32'h5A5A_1234;
  endfunction

  assign inst  = inst_of(addr);
  assign inst2 = inst_of(addr2);

  fetch_queue dut (
    .Clk(clk), .Clr(clr), .Redirect(redir), .Redirect_PC(rpc),
    .Imem_Addr(addr), .Imem_Inst(inst), .ID_Ready(ready),
    .Out_Valid(valid), .Out_PC(opc), .Out_PC4(opc4), .Out_Inst(oinst),
    .Count(count)
  );

  fetch_queue #(.DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) dut2 (
    .Clk(clk), .Clr(clr2), .Redirect(1'b0), .Redirect_PC(32'd0),
    .Imem_Addr(addr2), .Imem_Inst(inst2), .ID_Ready(1'b1),
    .Out_Valid(valid2), .Out_PC(opc2), .Out_PC4(opc42), .Out_Inst(oinst2),
    .Count(count2)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check1(input string tag, input logic ev, input logic [31:0] epc,
                        input logic [31:0] eaddr, input int ecnt, input bit ck_cnt);
    chk({tag, " valid"}, {31'd0, valid}, {31'd0, ev});
    chk({tag, " pc"},    opc,   ev ? epc : 32'd0);
    chk({tag, " pc4"},   opc4,  ev ? epc + 32'd4 : 32'd0);
    chk({tag, " inst"},  oinst, ev ? inst_of(epc) : 32'd0);
    chk({tag, " addr"},  addr,  eaddr);
    if (ck_cnt) chk({tag, " count"}, {29'd0, count}, ecnt);
  endtask

  typedef struct {
    logic        clr, redir;
    logic [31:0] rpc;
    logic        ready;
    logic        exp_valid;
    logic [31:0] exp_pc, exp_addr;
    int          exp_count;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic c, input logic r, input logic [31:0] p, input logic rd,
                     input logic ev, input logic [31:0] epc, input logic [31:0] ea, input int ec);
    vec_t v;
    v.clr = c; v.redir = r; v.rpc = p; v.ready = rd;
    v.exp_valid = ev; v.exp_pc = epc; v.exp_addr = ea; v.exp_count = ec;
    tbl.push_back(v);
  endtask

  // Reference model: a plain queue of fetched PCs plus the next fetch PC.
  logic [31:0] mq[$];
  logic [31:0] mpc;

  initial begin
    clr = 1'b1; redir = 1'b0; rpc = '0; ready = 1'b0; clr2 = 1'b1;

    // Streaming, stall/fill, full push+pop, redirect, clr-vs-redirect, double redirect.
    add(0,0,0,1, 0,0,32'h00,0);
    add(0,0,0,1, 1,32'h00,32'h04,1);
    add(0,0,0,1, 1,32'h04,32'h08,1);
    add(0,0,0,1, 1,32'h08,32'h0C,1);
    add(1,0,0,0, 0,0,32'h00,1);
    add(0,0,0,0, 0,0,32'h00,0);
    add(0,0,0,0, 1,32'h00,32'h04,1);
    add(0,0,0,0, 1,32'h00,32'h08,2);
    add(0,0,0,0, 1,32'h00,32'h0C,3);
    add(0,0,0,0, 1,32'h00,32'h10,4);
    add(0,0,0,0, 1,32'h00,32'h10,4);
    add(0,0,0,1, 1,32'h00,32'h10,4);
    add(0,0,0,1, 1,32'h04,32'h14,4);
    add(0,0,0,1, 1,32'h08,32'h18,4);
    add(0,0,0,1, 1,32'h0C,32'h1C,4);
    add(0,0,0,1, 1,32'h10,32'h20,4);
    add(0,0,0,0, 1,32'h14,32'h24,4);
    add(0,0,0,0, 1,32'h14,32'h24,4);
    add(1,0,0,0, 0,0,32'h00,4);
    add(0,0,0,0, 0,0,32'h00,0);
    add(0,0,0,0, 1,32'h00,32'h04,1);
    add(0,0,0,0, 1,32'h00,32'h08,2);
    add(0,1,32'h43,1, 0,0,32'h0C,3);
    add(0,0,0,0, 0,0,32'h40,0);
    add(0,0,0,0, 1,32'h40,32'h44,1);
    add(0,0,0,0, 1,32'h40,32'h48,2);
    add(1,1,32'h100,0, 0,0,32'h00,3);
    add(0,0,0,0, 0,0,32'h00,0);
    add(0,0,0,0, 1,32'h00,32'h04,1);
    add(0,1,32'h200,1, 0,0,32'h08,2);
    add(0,1,32'h305,1, 0,0,32'h200,0);
    add(0,0,0,1, 0,0,32'h304,0);
    add(0,0,0,1, 1,32'h304,32'h308,1);

    repeat (2) @(posedge clk);
    #1;
    foreach (tbl[i]) begin
      clr = tbl[i].clr; redir = tbl[i].redir; rpc = tbl[i].rpc; ready = tbl[i].ready;
      @(negedge clk);
      check1($sformatf("row%0d", i), tbl[i].exp_valid, tbl[i].exp_pc,
             tbl[i].exp_addr, tbl[i].exp_count, 1'b1);
      @(posedge clk);
      #1;
    end

    // Wrap of the fetch PC through 2^32 on the second instance.
    clr2 = 1'b0;
    @(negedge clk);
    chk("wrap0 valid", {31'd0, valid2}, 32'd0);
    chk("wrap0 addr", addr2, 32'hFFFF_FFF8);
    chk("wrap0 count", {29'd0, count2}, 32'd0);
    @(negedge clk);
    chk("wrap1 pc", opc2, 32'hFFFF_FFF8);
    chk("wrap1 addr", addr2, 32'hFFFF_FFFC);
    @(negedge clk);
    chk("wrap2 pc", opc2, 32'hFFFF_FFFC);
    chk("wrap2 pc4", opc42, 32'h0000_0000);
    chk("wrap2 inst", oinst2, inst_of(32'hFFFF_FFFC));
    chk("wrap2 addr", addr2, 32'h0000_0000);
    @(negedge clk);
    chk("wrap3 pc", opc2, 32'h0000_0000);
    chk("wrap3 pc4", opc42, 32'h0000_0004);
    @(posedge clk);
    #1;

    // Randomized run; model initialised by one unchecked reset cycle.
    clr = 1'b1; redir = 1'b0; ready = 1'b0;
    @(posedge clk);
    #1;
    mq.delete();
    mpc = 32'd0;
    for (int n = 0; n < 600; n++) begin
      logic c, r, rd, ev, p, pu;
      c  = ($urandom_range(0, 39) == 0);
      r  = ($urandom_range(0, 9) == 0);
      rd = ((n % 64) < 20) ? 1'b0 : ($urandom_range(0, 2) != 0);
      clr = c; redir = r; ready = rd; rpc = $urandom;
      @(negedge clk);
      ev = (mq.size() != 0) && !r && !c;
      check1($sformatf("rnd%0d", n), ev, ev ? mq[0] : 32'd0,
             c ? 32'd0 : mpc, mq.size(), 1'b1);
      if (c) begin
        mq.delete();
        mpc = 32'd0;
      end else if (r) begin
        mq.delete();
        mpc = {rpc[31:2], 2'b00};
      end else begin
        p  = ev && rd;
        pu = (mq.size() < 4) || p;
        if (p) void'(mq.pop_front());
        if (pu) begin
          mq.push_back(mpc);
          mpc = mpc + 32'd4;
        end
      end
      @(posedge clk);
      #1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
